// File: rtl/prim_ram_2p_pipe.sv
// prim_ram_2p_pipe: dual-port RAM with grouped write masks and a 1- or 2-cycle read pipeline
module prim_ram_2p_pipe #(
  parameter int Width = 32,
  parameter int Depth = 128,
  parameter int DataBitsPerMask = 1,
  parameter int OutputReg = 0,
  parameter int RdwNewData = 1,
  parameter int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             collision_o
);
  localparam int Dbm = DataBitsPerMask;
  if (Width % Dbm != 0) begin : g_bad_mask
    $error("Width must be a multiple of DataBitsPerMask");
  end
  if (Depth < 2) begin : g_bad_depth
    $error("Depth must be at least 2");
  end
  logic [Width-1:0] mem [Depth];
  logic [1:0] req, wr, inr, we, re, v1, rv_q, sv;
  logic [1:0][Aw-1:0] addr;
  logic [1:0][Width-1:0] wdata, wmask, bm, old, rd, d1, rd_q, sd;
  logic [Width-1:0] a_new, b_new;
  logic same, coll_q;
  assign req   = {b_req_i, a_req_i};
  assign wr    = {b_write_i, a_write_i};
  assign addr  = {b_addr_i, a_addr_i};
  assign wdata = {b_wdata_i, a_wdata_i};
  assign wmask = {b_wmask_i, a_wmask_i};
  assign same  = addr[0] == addr[1];
  always_comb begin
    bm = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < Width / Dbm; k++)
        bm[p][k*Dbm +: Dbm] = {Dbm{&wmask[p][k*Dbm +: Dbm]}};
  end
  // Port A is merged on top of port B so A wins in groups both ports enable
  always_comb begin
    inr = '0;
    we  = '0;
    re  = '0;
    old = '0;
    for (int p = 0; p < 2; p++) begin
      inr[p] = 32'(addr[p]) < Depth;
      we[p]  = rst_ni & req[p] & wr[p] & inr[p];
      re[p]  = rst_ni & req[p] & ~wr[p];
      old[p] = inr[p] ? mem[addr[p]] : '0;
    end
    b_new = (old[1] & ~bm[1]) | (wdata[1] & bm[1]);
    a_new = (((we[1] && same) ? b_new : old[0]) & ~bm[0]) | (wdata[0] & bm[0]);
    rd[0] = (RdwNewData != 0 && we[1] && same) ? b_new : old[0];
    rd[1] = (RdwNewData != 0 && we[0] && same) ? a_new : old[1];
  end
  always_ff @(posedge clk_i) begin
    if (we[1]) mem[addr[1]] <= b_new;
    if (we[0]) mem[addr[0]] <= a_new;
  end
  assign sv = (OutputReg != 0) ? v1 : re;
  assign sd = (OutputReg != 0) ? d1 : rd;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1     <= '0;
      d1     <= '0;
      rv_q   <= '0;
      rd_q   <= '0;
      coll_q <= 1'b0;
    end else begin
      v1     <= re;
      d1     <= rd;
      rv_q   <= sv;
      for (int p = 0; p < 2; p++) if (sv[p]) rd_q[p] <= sd[p];
      coll_q <= we[0] & we[1] & same;
    end
  end
  assign a_rvalid_o  = rv_q[0];
  assign b_rvalid_o  = rv_q[1];
  assign a_rdata_o   = rd_q[0];
  assign b_rdata_o   = rd_q[1];
  assign collision_o = coll_q;
endmodule

// File: tb/tb_prim_ram_2p_pipe.sv
// tb_prim_ram_2p_pipe: two RAM configurations driven in lockstep against an array-based reference
module tb_prim_ram_2p_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] req, wr;
  logic [1:0][6:0] addr;
  logic [1:0][31:0] wd, wm;
  logic obs_rv [2][2];
  logic [31:0] obs_rd [2][2];
  logic obs_col [2];
  logic [31:0] mm [2][128];
  logic sched_v [2][2][4];
  logic [31:0] sched_d [2][2][4];
  logic [31:0] last [2][2];
  logic erv [2][2];
  logic [31:0] erd [2][2];
  logic ecol [2];
  int cyc, cmp, bad;

  // dut0: Depth 100, bit masks, latency 1, new-data RDW; dut1: Depth 128, byte masks, latency 2, old-data RDW
  prim_ram_2p_pipe #(.Width(32), .Depth(100), .DataBitsPerMask(1), .OutputReg(0), .RdwNewData(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(req[0]), .a_write_i(wr[0]), .a_addr_i(addr[0]), .a_wdata_i(wd[0]), .a_wmask_i(wm[0]),
    .a_rvalid_o(obs_rv[0][0]), .a_rdata_o(obs_rd[0][0]),
    .b_req_i(req[1]), .b_write_i(wr[1]), .b_addr_i(addr[1]), .b_wdata_i(wd[1]), .b_wmask_i(wm[1]),
    .b_rvalid_o(obs_rv[0][1]), .b_rdata_o(obs_rd[0][1]),
    .collision_o(obs_col[0]));
  prim_ram_2p_pipe #(.Width(32), .Depth(128), .DataBitsPerMask(8), .OutputReg(1), .RdwNewData(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(req[0]), .a_write_i(wr[0]), .a_addr_i(addr[0]), .a_wdata_i(wd[0]), .a_wmask_i(wm[0]),
    .a_rvalid_o(obs_rv[1][0]), .a_rdata_o(obs_rd[1][0]),
    .b_req_i(req[1]), .b_write_i(wr[1]), .b_addr_i(addr[1]), .b_wdata_i(wd[1]), .b_wmask_i(wm[1]),
    .b_rvalid_o(obs_rv[1][1]), .b_rdata_o(obs_rd[1][1]),
    .collision_o(obs_col[1]));

  function automatic logic [31:0] emask(input logic [31:0] m, input int g);
    logic [31:0] r, gm;
    r = '0;
    gm = 32'((64'd1 << g) - 64'd1);
    for (int k = 0; k < 32; k += g) if (((m >> k) & gm) == gm) r |= gm << k;
    return r;
  endfunction

  // One clock of stimulus: update the reference, clock the DUTs, then publish expected outputs
  task automatic step();
    logic [31:0] old [2];
    logic [31:0] em [2];
    logic [1:0] wv;
    int dep, s;
    for (int d = 0; d < 2; d++) begin
      dep = d ? 128 : 100;
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          for (int k = 0; k < 4; k++) sched_v[d][p][k] = 1'b0;
          last[d][p] = '0;
        end
        ecol[d] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          em[p]  = emask(wm[p], d ? 8 : 1);
          wv[p]  = req[p] && wr[p] && int'(addr[p]) < dep;
          old[p] = int'(addr[p]) < dep ? mm[d][addr[p]] : 32'h0;
        end
        for (int p = 1; p >= 0; p--)
          if (wv[p]) mm[d][addr[p]] = (mm[d][addr[p]] & ~em[p]) | (wd[p] & em[p]);
        ecol[d] = wv[0] && wv[1] && addr[0] == addr[1];
        for (int p = 0; p < 2; p++)
          if (req[p] && !wr[p]) begin
            s = (cyc + (d ? 2 : 1)) % 4;
            sched_v[d][p][s] = 1'b1;
            sched_d[d][p][s] = int'(addr[p]) >= dep ? 32'h0 : (d == 0 ? mm[d][addr[p]] : old[p]);
          end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        erv[d][p] = sched_v[d][p][cyc % 4];
        if (erv[d][p]) last[d][p] = sched_d[d][p][cyc % 4];
        sched_v[d][p][cyc % 4] = 1'b0;
        erd[d][p] = last[d][p];
      end
  endtask

  task automatic idle();
    req = '0;
    wr  = '0;
  endtask

  task automatic drv(input int p, input logic w, input logic [6:0] a, input logic [31:0] d, input logic [31:0] m);
    req[p]  = 1'b1;
    wr[p]   = w;
    addr[p] = a;
    wd[p]   = d;
    wm[p]   = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1; wr = '1; addr = '0; wd = '1; wm = '1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      cmp++; if (obs_col[d] !== 1'b0) begin bad++; $display("FAIL reset collision dut%0d got %b want 0", d, obs_col[d]); end
      for (int p = 0; p < 2; p++) begin
        cmp++; if (obs_rv[d][p] !== 1'b0) begin bad++; $display("FAIL reset rvalid dut%0d p%0d got %b want 0", d, p, obs_rv[d][p]); end
        cmp++; if (obs_rd[d][p] !== 32'h0) begin bad++; $display("FAIL reset rdata dut%0d p%0d got %h want 0", d, p, obs_rd[d][p]); end
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) begin
      req = '1; wr = '1; wm = '1;
      addr[0] = 7'(2 * i); addr[1] = 7'(2 * i + 1);
      wd[0] = $urandom; wd[1] = $urandom;
      step();
    end
    idle();
  endtask

  task automatic test_write_read();
    idle(); drv(0, 1'b1, 7'd5, 32'hDEADBEEF, '1); step();
    idle(); drv(1, 1'b0, 7'd5, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rv[0][1] !== 1'b1) begin bad++; $display("FAIL wr_rd lat1 rvalid got %b want 1", obs_rv[0][1]); end
    cmp++; if (obs_rd[0][1] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd lat1 rdata got %h want deadbeef", obs_rd[0][1]); end
    cmp++; if (obs_rv[1][1] !== 1'b0) begin bad++; $display("FAIL wr_rd lat2 early rvalid got %b want 0", obs_rv[1][1]); end
    step();
    cmp++; if (obs_rv[1][1] !== 1'b1) begin bad++; $display("FAIL wr_rd lat2 rvalid got %b want 1", obs_rv[1][1]); end
    cmp++; if (obs_rd[1][1] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd lat2 rdata got %h want deadbeef", obs_rd[1][1]); end
    cmp++; if (obs_rv[0][1] !== 1'b0) begin bad++; $display("FAIL wr_rd single pulse got %b want 0", obs_rv[0][1]); end
    cmp++; if (obs_rd[0][1] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd hold rdata got %h want deadbeef", obs_rd[0][1]); end
  endtask

  task automatic test_mask();
    idle(); drv(0, 1'b1, 7'd3, 32'h11223344, '1); step();
    idle(); drv(0, 1'b1, 7'd3, 32'hAABBCCDD, 32'h00FF00FF); step();
    idle(); drv(0, 1'b0, 7'd3, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rd[0][0] !== 32'h11BB33DD) begin bad++; $display("FAIL mask bit rdata got %h want 11bb33dd", obs_rd[0][0]); end
    cmp++; if (obs_rv[1][0] !== 1'b0) begin bad++; $display("FAIL mask lat2 early rvalid got %b want 0", obs_rv[1][0]); end
    step();
    cmp++; if (obs_rv[1][0] !== 1'b1) begin bad++; $display("FAIL mask byte rvalid got %b want 1", obs_rv[1][0]); end
    cmp++; if (obs_rd[1][0] !== 32'h11BB33DD) begin bad++; $display("FAIL mask byte rdata got %h want 11bb33dd", obs_rd[1][0]); end
    drv(0, 1'b1, 7'd3, 32'hFFFFFFFF, 32'h0FFFFFF0); step();
    idle(); drv(0, 1'b0, 7'd3, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rd[0][0] !== 32'h1FFFFFFD) begin bad++; $display("FAIL partial bit rdata got %h want 1ffffffd", obs_rd[0][0]); end
    step();
    cmp++; if (obs_rd[1][0] !== 32'h11FFFFDD) begin bad++; $display("FAIL partial group rdata got %h want 11ffffdd", obs_rd[1][0]); end
  endtask

  task automatic test_rdw();
    idle(); drv(0, 1'b1, 7'd7, 32'h9, '1); step();
    idle(); drv(0, 1'b1, 7'd7, 32'h5, '1); drv(1, 1'b0, 7'd7, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rd[0][1] !== 32'h5) begin bad++; $display("FAIL rdw new rdata got %h want 5", obs_rd[0][1]); end
    step();
    cmp++; if (obs_rd[1][1] !== 32'h9) begin bad++; $display("FAIL rdw old rdata got %h want 9", obs_rd[1][1]); end
    drv(1, 1'b0, 7'd7, 32'h0, 32'h0); step(); idle();
    step();
    cmp++; if (obs_rd[1][1] !== 32'h5) begin bad++; $display("FAIL rdw after write rdata got %h want 5", obs_rd[1][1]); end
  endtask

  task automatic test_collision();
    idle(); drv(0, 1'b1, 7'd2, 32'hAAAA0000, 32'hFFFF0000); drv(1, 1'b1, 7'd2, 32'h0000BBBB, '1); step(); idle();
    for (int d = 0; d < 2; d++) begin
      cmp++; if (obs_col[d] !== 1'b1) begin bad++; $display("FAIL collision pulse dut%0d got %b want 1", d, obs_col[d]); end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      cmp++; if (obs_col[d] !== 1'b0) begin bad++; $display("FAIL collision clear dut%0d got %b want 0", d, obs_col[d]); end
    end
    drv(0, 1'b0, 7'd2, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rd[0][0] !== 32'hAAAABBBB) begin bad++; $display("FAIL collision data dut0 got %h want aaaabbbb", obs_rd[0][0]); end
    step();
    cmp++; if (obs_rd[1][0] !== 32'hAAAABBBB) begin bad++; $display("FAIL collision data dut1 got %h want aaaabbbb", obs_rd[1][0]); end
  endtask

  task automatic test_range();
    idle(); drv(1, 1'b1, 7'd99, 32'hC0FFEE99, '1); step();
    idle(); drv(0, 1'b1, 7'd120, 32'h12345678, '1); step();
    idle(); drv(0, 1'b0, 7'd120, 32'h0, 32'h0); drv(1, 1'b0, 7'd99, 32'h0, 32'h0); step(); idle();
    cmp++; if (obs_rv[0][0] !== 1'b1) begin bad++; $display("FAIL range rvalid got %b want 1", obs_rv[0][0]); end
    cmp++; if (obs_rd[0][0] !== 32'h0) begin bad++; $display("FAIL range rdata got %h want 0", obs_rd[0][0]); end
    cmp++; if (obs_rd[0][1] !== 32'hC0FFEE99) begin bad++; $display("FAIL range last word got %h want c0ffee99", obs_rd[0][1]); end
    step();
    cmp++; if (obs_rd[1][0] !== 32'h12345678) begin bad++; $display("FAIL range full depth got %h want 12345678", obs_rd[1][0]); end
  endtask

  task automatic test_back_to_back();
    idle(); drv(0, 1'b1, 7'd1, 32'h0BADCAFE, '1); step(); idle();
    for (int i = 0; i < 7; i++) begin
      idle();
      rst_n = (i != 2);
      if (i < 3) drv(0, 1'b0, 7'(i), 32'h0, 32'h0);
      if (i == 2) drv(1, 1'b1, 7'd1, 32'hDEADDEAD, '1);
      if (i == 6) drv(0, 1'b0, 7'd1, 32'h0, 32'h0);
      step();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          cmp++; if (obs_rv[d][p] !== erv[d][p]) begin bad++; $display("FAIL b2b rvalid dut%0d p%0d step %0d got %b want %b", d, p, i, obs_rv[d][p], erv[d][p]); end
          cmp++; if (obs_rd[d][p] !== erd[d][p]) begin bad++; $display("FAIL b2b rdata dut%0d p%0d step %0d got %h want %h", d, p, i, obs_rd[d][p], erd[d][p]); end
          if (i >= 2 && i <= 5) begin
            cmp++; if (obs_rv[d][p] !== 1'b0) begin bad++; $display("FAIL b2b dropped rvalid dut%0d p%0d step %0d got %b want 0", d, p, i, obs_rv[d][p]); end
          end
        end
    end
    idle();
    cmp++; if (obs_rd[0][0] !== 32'h0BADCAFE) begin bad++; $display("FAIL b2b preserved dut0 got %h want 0badcafe", obs_rd[0][0]); end
    step();
    cmp++; if (obs_rd[1][0] !== 32'h0BADCAFE) begin bad++; $display("FAIL b2b preserved dut1 got %h want 0badcafe", obs_rd[1][0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 49) != 0;
      for (int p = 0; p < 2; p++) begin
        req[p]  = $urandom_range(0, 3) != 0;
        wr[p]   = 1'($urandom_range(0, 1));
        addr[p] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7));
        wd[p]   = $urandom;
        case ($urandom_range(0, 3))
          0: wm[p] = '1;
          1: for (int b = 0; b < 4; b++) wm[p][8*b +: 8] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
          2: wm[p] = $urandom;
          default: wm[p] = '0;
        endcase
      end
      step();
      for (int d = 0; d < 2; d++) begin
        cmp++; if (obs_col[d] !== ecol[d]) begin bad++; $display("FAIL rnd collision dut%0d cyc %0d got %b want %b", d, cyc, obs_col[d], ecol[d]); end
        for (int p = 0; p < 2; p++) begin
          cmp++; if (obs_rv[d][p] !== erv[d][p]) begin bad++; $display("FAIL rnd rvalid dut%0d p%0d cyc %0d got %b want %b", d, p, cyc, obs_rv[d][p], erv[d][p]); end
          cmp++; if (obs_rd[d][p] !== erd[d][p]) begin bad++; $display("FAIL rnd rdata dut%0d p%0d cyc %0d got %h want %h", d, p, cyc, obs_rd[d][p], erd[d][p]); end
        end
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    cyc = 0; cmp = 0; bad = 0;
    rst_n = 1'b0;
    req = '0; wr = '0; addr = '0; wd = '0; wm = '0;
    test_reset();
    init_mem();
    test_write_read();
    test_mask();
    test_rdw();
    test_collision();
    test_range();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
